// File: rtl/input_cmd_queue.sv
// Latches one-cycle button pulses and gravity ticks per source, arbitrates them by
// fixed priority into a small FIFO, and serves the head to the game-logic FSM.
module input_cmd_queue #(
  parameter int DEPTH         = 4,
  parameter int GRAVITY_TICKS = 50000000,
  parameter int TICK_W        = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_rotate,
  input  logic                     btn_down,
  input  logic                     pause,
  output logic                     cmd_valid,
  output logic [2:0]               cmd,
  input  logic                     cmd_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int NSRC = 5;

  // Source index i is enqueued as command code i+1.
  localparam int SRC_LEFT   = 0;
  localparam int SRC_RIGHT  = 1;
  localparam int SRC_ROTATE = 2;
  localparam int SRC_DOWN   = 3;
  localparam int SRC_GRAV   = 4;

  localparam logic [LW-1:0]     FULL_LVL  = LW'(DEPTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(GRAVITY_TICKS - 1);

  logic [NSRC-1:0]   pend_q, pend_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        mem_q [DEPTH];
  logic [2:0]        mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [7:0]        drop_q, drop_d;

  logic [NSRC-1:0]   pulse;
  logic [NSRC-1:0]   grant;
  logic [NSRC-1:0]   merge;
  logic              grav_wrap;
  logic              pop;
  logic              push;
  logic              can_accept;
  logic [2:0]        push_cmd;
  logic [2:0]        merge_n;
  logic [8:0]        drop_sum;

  // Handshake: the head is transferred on any rising edge where cmd_valid and
  // cmd_ready are both 1; cmd holds steady while cmd_valid=1 and cmd_ready=0.
  always_comb begin
    pop        = (level_q != '0) && cmd_ready;
    can_accept = (level_q != FULL_LVL) || pop;
    grav_wrap  = !pause && (tick_q == TICK_LAST);

    pulse             = '0;
    pulse[SRC_LEFT]   = btn_left   & ~pause;
    pulse[SRC_RIGHT]  = btn_right  & ~pause;
    pulse[SRC_ROTATE] = btn_rotate & ~pause;
    pulse[SRC_DOWN]   = btn_down   & ~pause;
    pulse[SRC_GRAV]   = grav_wrap;

    grant = '0;
    if (can_accept) begin
      if (pend_q[SRC_GRAV])        grant[SRC_GRAV]   = 1'b1;
      else if (pend_q[SRC_DOWN])   grant[SRC_DOWN]   = 1'b1;
      else if (pend_q[SRC_ROTATE]) grant[SRC_ROTATE] = 1'b1;
      else if (pend_q[SRC_LEFT])   grant[SRC_LEFT]   = 1'b1;
      else if (pend_q[SRC_RIGHT])  grant[SRC_RIGHT]  = 1'b1;
    end
    push = |grant;

    push_cmd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) push_cmd = 3'(i + 1);
    end

    // A pulse arriving on the cycle its bit is granted re-arms the bit and is not a drop.
    merge  = pulse & pend_q & ~grant;
    pend_d = (pend_q & ~grant) | pulse;

    merge_n = '0;
    for (int i = 0; i < NSRC; i++) begin
      merge_n = merge_n + {2'b00, merge[i]};
    end
    drop_sum = {1'b0, drop_q} + {6'b0, merge_n};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    tick_d = tick_q;
    if (!pause) tick_d = grav_wrap ? '0 : tick_q + 1'b1;
    if (grant[SRC_DOWN]) tick_d = '0;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_cmd;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      tick_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign cmd_valid  = (level_q != '0);
  assign cmd        = cmd_valid ? mem_q[rd_ptr_q] : 3'd0;
  assign fifo_level = level_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_input_cmd_queue.sv
// Directed bench for input_cmd_queue: one instance with a long gravity period for
// button scenarios, one with an 8-cycle period for gravity timing.
module tb_input_cmd_queue;

  logic       clk;
  logic       rst_n;
  logic       btn_left, btn_right, btn_rotate, btn_down, pause, cmd_ready;
  logic       cmd_valid, g_cmd_valid;
  logic [2:0] cmd, g_cmd;
  logic [2:0] fifo_level, g_fifo_level;
  logic [7:0] drop_cnt, g_drop_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  input_cmd_queue #(.DEPTH(4), .GRAVITY_TICKS(1000), .TICK_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate), .btn_down(btn_down),
    .pause(pause), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  input_cmd_queue #(.DEPTH(4), .GRAVITY_TICKS(8), .TICK_W(4)) u_grav (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate), .btn_down(btn_down),
    .pause(pause), .cmd_valid(g_cmd_valid), .cmd(g_cmd), .cmd_ready(cmd_ready),
    .fifo_level(g_fifo_level), .drop_cnt(g_drop_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1);
  end

  // Driver tasks: inputs change on the falling edge, outputs are sampled there too.
  task automatic clear_inputs();
    btn_left = 0; btn_right = 0; btn_rotate = 0; btn_down = 0; pause = 0; cmd_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (cmd_valid !== 1'b0) $display("FAIL reset_valid: got %0b exp 0", cmd_valid); else pass_cnt++;
    total_cnt++; if (cmd !== 3'd0) $display("FAIL reset_cmd: got %0d exp 0", cmd); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d exp 0", fifo_level); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0d exp 0", drop_cnt); else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    cmd_ready = 1; btn_left = 1;
    @(negedge clk); btn_left = 0;
    total_cnt++; if (cmd_valid !== 1'b0) $display("FAIL single_early: got %0b exp 0", cmd_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (cmd_valid !== 1'b1) $display("FAIL single_valid: got %0b exp 1", cmd_valid); else pass_cnt++;
    total_cnt++; if (cmd !== 3'd1) $display("FAIL single_cmd: got %0d exp 1", cmd); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (cmd_valid !== 1'b0) $display("FAIL single_one_cycle: got %0b exp 0", cmd_valid); else pass_cnt++;
    total_cnt++; if (cmd !== 3'd0) $display("FAIL single_cmd_empty: got %0d exp 0", cmd); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL single_drop: got %0d exp 0", drop_cnt); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int exp_seq [4] = '{4, 3, 1, 2};
    do_reset();
    cmd_ready = 1; btn_left = 1; btn_right = 1; btn_rotate = 1; btn_down = 1;
    @(negedge clk); btn_left = 0; btn_right = 0; btn_rotate = 0; btn_down = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if (cmd_valid !== 1'b1 || cmd !== 3'(exp_seq[i]))
        $display("FAIL simul_seq%0d: got valid=%0b cmd=%0d exp valid=1 cmd=%0d", i, cmd_valid, cmd, exp_seq[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (cmd_valid !== 1'b0) $display("FAIL simul_drained: got %0b exp 0", cmd_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int exp_seq [5] = '{1, 2, 3, 4, 1};
    do_reset();
    btn_left = 1;
    @(negedge clk); btn_left = 0; btn_right = 1;
    @(negedge clk); btn_right = 0; btn_rotate = 1;
    @(negedge clk); btn_rotate = 0; btn_down = 1;
    @(negedge clk); btn_down = 0; btn_left = 1;
    @(negedge clk); btn_left = 0;
    total_cnt++; if (fifo_level !== 3'd4) $display("FAIL bp_full: got %0d exp 4", fifo_level); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL bp_nodrop: got %0d exp 0", drop_cnt); else pass_cnt++;
    btn_left = 1;
    @(negedge clk); btn_left = 0;
    total_cnt++; if (drop_cnt !== 8'd1) $display("FAIL bp_merge: got %0d exp 1", drop_cnt); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd4) $display("FAIL bp_still_full: got %0d exp 4", fifo_level); else pass_cnt++;
    total_cnt++; if (cmd !== 3'd1) $display("FAIL bp_head_stable: got %0d exp 1", cmd); else pass_cnt++;
    cmd_ready = 1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (cmd_valid !== 1'b1 || cmd !== 3'(exp_seq[i]))
        $display("FAIL bp_drain%0d: got valid=%0b cmd=%0d exp valid=1 cmd=%0d", i, cmd_valid, cmd, exp_seq[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (cmd_valid !== 1'b0) $display("FAIL bp_empty: got %0b exp 0", cmd_valid); else pass_cnt++;
  endtask

  task automatic test_push_pop_full();
    int exp_seq [4] = '{3, 1, 3, 2};
    do_reset();
    btn_left = 1;
    @(negedge clk); btn_left = 0; btn_rotate = 1;
    @(negedge clk); btn_rotate = 0; btn_left = 1;
    @(negedge clk); btn_left = 0; btn_rotate = 1;
    @(negedge clk); btn_rotate = 0; btn_right = 1;
    @(negedge clk); btn_right = 0;
    total_cnt++; if (fifo_level !== 3'd4) $display("FAIL pp_full: got %0d exp 4", fifo_level); else pass_cnt++;
    total_cnt++; if (cmd !== 3'd1) $display("FAIL pp_head: got %0d exp 1", cmd); else pass_cnt++;
    cmd_ready = 1;
    @(negedge clk);
    total_cnt++; if (fifo_level !== 3'd4) $display("FAIL pp_level_held: got %0d exp 4", fifo_level); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (cmd_valid !== 1'b1 || cmd !== 3'(exp_seq[i]))
        $display("FAIL pp_order%0d: got valid=%0b cmd=%0d exp valid=1 cmd=%0d", i, cmd_valid, cmd, exp_seq[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (cmd_valid !== 1'b0) $display("FAIL pp_empty: got %0b exp 0", cmd_valid); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL pp_drop: got %0d exp 0", drop_cnt); else pass_cnt++;
  endtask

  task automatic test_clear_and_pulse();
    do_reset();
    cmd_ready = 1; btn_left = 1;
    @(negedge clk);
    @(negedge clk); btn_left = 0;
    total_cnt++; if (cmd !== 3'd1) $display("FAIL cp_first: got %0d exp 1", cmd); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (cmd_valid !== 1'b1 || cmd !== 3'd1) $display("FAIL cp_second: got valid=%0b cmd=%0d exp valid=1 cmd=1", cmd_valid, cmd); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (cmd_valid !== 1'b0) $display("FAIL cp_empty: got %0b exp 0", cmd_valid); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL cp_drop: got %0d exp 0", drop_cnt); else pass_cnt++;
  endtask

  task automatic test_pause();
    do_reset();
    cmd_ready = 1; btn_left = 1;
    @(negedge clk); btn_left = 0; pause = 1; btn_rotate = 1;
    @(negedge clk); btn_rotate = 0;
    total_cnt++; if (cmd_valid !== 1'b1 || cmd !== 3'd1) $display("FAIL pause_drain: got valid=%0b cmd=%0d exp valid=1 cmd=1", cmd_valid, cmd); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (cmd_valid !== 1'b0) $display("FAIL pause_discard: got %0b exp 0", cmd_valid); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL pause_drop: got %0d exp 0", drop_cnt); else pass_cnt++;
    pause = 0;
  endtask

  task automatic test_drop_saturation();
    do_reset();
    btn_left = 1;
    repeat (10) @(negedge clk);
    total_cnt++; if (drop_cnt !== 8'd5) $display("FAIL sat_early: got %0d exp 5", drop_cnt); else pass_cnt++;
    repeat (249) @(negedge clk);
    total_cnt++; if (drop_cnt !== 8'd254) $display("FAIL sat_254: got %0d exp 254", drop_cnt); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (drop_cnt !== 8'd255) $display("FAIL sat_255: got %0d exp 255", drop_cnt); else pass_cnt++;
    repeat (40) @(negedge clk);
    total_cnt++; if (drop_cnt !== 8'd255) $display("FAIL sat_hold: got %0d exp 255", drop_cnt); else pass_cnt++;
    btn_left = 0;
  endtask

  task automatic test_gravity();
    logic exp_v;
    do_reset();
    cmd_ready = 1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      exp_v = (n == 9) || (n == 17);
      total_cnt++;
      if (g_cmd_valid !== exp_v || (exp_v && g_cmd !== 3'd5))
        $display("FAIL grav_n%0d: got valid=%0b cmd=%0d exp valid=%0b cmd=5", n, g_cmd_valid, g_cmd, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_gravity_pause();
    logic exp_v;
    do_reset();
    cmd_ready = 1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      exp_v = (n == 14);
      total_cnt++;
      if (g_cmd_valid !== exp_v || (exp_v && g_cmd !== 3'd5))
        $display("FAIL gpause_n%0d: got valid=%0b cmd=%0d exp valid=%0b cmd=5", n, g_cmd_valid, g_cmd, exp_v);
      else pass_cnt++;
      pause = (n >= 3) && (n <= 7);
    end
  endtask

  task automatic test_gravity_down();
    logic       exp_v;
    logic [2:0] exp_c;
    do_reset();
    cmd_ready = 1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      exp_v = (n == 5) || (n == 14);
      exp_c = (n == 5) ? 3'd4 : 3'd5;
      total_cnt++;
      if (g_cmd_valid !== exp_v || (exp_v && g_cmd !== exp_c))
        $display("FAIL gdown_n%0d: got valid=%0b cmd=%0d exp valid=%0b cmd=%0d", n, g_cmd_valid, g_cmd, exp_v, exp_c);
      else pass_cnt++;
      btn_down = (n == 3);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    btn_left = 1; btn_rotate = 1;
    @(negedge clk); btn_rotate = 0;
    @(negedge clk); btn_left = 0; btn_right = 1;
    @(negedge clk); btn_right = 0;
    @(negedge clk);
    total_cnt++; if (fifo_level !== 3'd3) $display("FAIL ar_pre_level: got %0d exp 3", fifo_level); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd1) $display("FAIL ar_pre_drop: got %0d exp 1", drop_cnt); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (cmd_valid !== 1'b0) $display("FAIL ar_valid: got %0b exp 0", cmd_valid); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd0) $display("FAIL ar_level: got %0d exp 0", fifo_level); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL ar_drop: got %0d exp 0", drop_cnt); else pass_cnt++;
    total_cnt++; if (cmd !== 3'd0) $display("FAIL ar_cmd: got %0d exp 0", cmd); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; cmd_ready = 1; btn_left = 1;
    @(negedge clk); btn_left = 0;
    @(negedge clk);
    total_cnt++; if (cmd_valid !== 1'b1 || cmd !== 3'd1) $display("FAIL ar_post: got valid=%0b cmd=%0d exp valid=1 cmd=1", cmd_valid, cmd); else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_push_pop_full();
    test_clear_and_pulse();
    test_pause();
    test_drop_saturation();
    test_gravity();
    test_gravity_pause();
    test_gravity_down();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/input_cmd_queue.md
# input_cmd_queue

Converts one-cycle button pulses from the per-button debouncers, plus an internal gravity timer, into a serialized stream of game commands for the Tetris game-logic FSM. Pulses are latched per source, arbitrated by fixed priority into a small FIFO, and drained through a valid/ready handshake. This lets the game engine consume at most one move per cycle without losing near-simultaneous presses.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2.
- GRAVITY_TICKS, 50000000, clk cycles between gravity commands; ≥2.
- TICK_W, 26, gravity counter width; must hold GRAVITY_TICKS-1.

- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_left  in  1  one-cycle pulse from debouncer.
- btn_right  in  1  one-cycle pulse from debouncer.
- btn_rotate  in  1  one-cycle pulse from debouncer.
- btn_down  in  1  one-cycle pulse from debouncer (soft drop).
- pause  in  1  level; freezes gravity and discards button pulses.
- cmd_valid  out  1  FIFO head valid.
- cmd  out  3  head command: 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DOWN, 5 GRAVITY; 0 when empty.
- cmd_ready  in  1  consumer accepts head this cycle.
- fifo_level  out  log2(DEPTH)+1  current entry count.
- drop_cnt  out  8  saturating count of merged/discarded pulses.

## Operation
- Reset: all pending bits 0, FIFO empty, gravity counter 0, cmd_valid 0, cmd 0, fifo_level 0, drop_cnt 0.
- Pending latch: one bit per source (LEFT, RIGHT, ROTATE, DOWN, GRAVITY). A pulse with pause=0 sets its bit. A pulse while its bit is already set, and not cleared this cycle, is merged: drop_cnt += 1 (saturates at 255). A pulse with pause=1 is discarded without counting.
- Gravity: counter increments each cycle when pause=0, holds when pause=1. On reaching GRAVITY_TICKS-1 it wraps to 0 and sets GRAVITY pending. Merge rules match buttons.
- Counter clears to 0 in the cycle a DOWN entry is enqueued. A wrap in that same cycle still sets GRAVITY pending.
- Arbiter: each cycle, if any pending bit is set and the FIFO can accept, exactly one entry is enqueued and its pending bit is cleared.
  - Priority: GRAVITY > DOWN > ROTATE > LEFT > RIGHT.
- FIFO can accept when fifo_level < DEPTH, or fifo_level == DEPTH and a pop occurs this cycle.
- Pending bits are not cleared while the FIFO is full, so the queue applies backpressure to the latches.
- Pop: when cmd_valid && cmd_ready, the head is removed. cmd_ready while empty has no effect.
- Push and pop in one cycle leave fifo_level unchanged. Pointers wrap modulo DEPTH.
- Pending bit clear and new pulse on the same source in the same cycle: the bit stays set, not counted as a drop.
- pause does not stall the FIFO drain or the arbiter. Entries already pending or queued still deliver.

## Timing
- A pulse sampled at edge E0 sets pending. With an empty FIFO and no higher-priority pending, the entry is written at E1. cmd_valid/cmd go high after E1, giving a 2-cycle latency.
- cmd_valid = (fifo_level != 0), driven from registers; no combinational path from inputs.
- cmd is stable while cmd_valid=1 and cmd_ready=0.
- Throughput: one enqueue and one dequeue per cycle max.
- Reset assertion mid-operation immediately empties the FIFO and clears all state. The first valid edge after deassertion behaves as post-reset.

## Test plan
- Single press: btn_left pulse at cycle 10, cmd_ready=1 → cmd_valid=1 with cmd=1 for exactly one cycle after edge 12. drop_cnt=0.
- Simultaneous: left, right, rotate, down pulsed in the same cycle, cmd_ready=1 → cmd sequence 4,3,1,2 on consecutive cycles.
- Backpressure: cmd_ready=0, DEPTH=4. Pulse left, right, rotate, down on separate cycles, then left twice.
  - Required: fifo_level=4 with entries 1,2,3,4.
  - LEFT stays pending; second left pulse gives drop_cnt=1.
  - Raising cmd_ready then yields 1,2,3,4,1.
- Gravity: GRAVITY_TICKS=8, no buttons → cmd=5 every 8 cycles.
  - pause=1 for 5 cycles mid-count delays the next cmd=5 by 5 cycles.
  - btn_down enqueue restarts the 8-cycle interval.
- Simultaneous push/pop at full: fifo_level=4, cmd_ready=1 with a pending RIGHT → fifo_level stays 4 and order is preserved.
- Async reset: assert rst_n=0 between edges with fifo_level=3 → cmd_valid, fifo_level, drop_cnt are 0 immediately, before the next clk edge.
